// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state type and latency constants for the SRAM bank
package sram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - single-port word array with byte-lane writes and registered read
module sram_array #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10,
    parameter int MEMDEPTH  = 1 << ADDRWIDTH
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [ADDRWIDTH-1:0]   addr_i,
    input  logic [DATAWIDTH/8-1:0] be_i,
    input  logic [DATAWIDTH-1:0]   wdata_i,
    output logic [DATAWIDTH-1:0]   rdata_o
);

    localparam int NB = DATAWIDTH / 8;

    logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];
    logic [DATAWIDTH-1:0] rdata_q;

    // The read register only moves on a read, so it naturally holds between reads.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - SRAM bank: clear sweep, request handling, read/error pipeline
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATAWIDTH      = 32,
    parameter int ADDRWIDTH      = 10,
    parameter int MEMDEPTH       = 1 << ADDRWIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic                   REQ_WRITE,
    input  logic [ADDRWIDTH-1:0]   ADDRESS,
    input  logic [DATAWIDTH/8-1:0] WSTRB,
    input  logic [DATAWIDTH-1:0]   WDATA,
    output logic                   RVALID,
    output logic [DATAWIDTH-1:0]   RDATA,
    output logic                   INIT_DONE,
    output logic                   ERR_ADDR
);

    localparam int              CW        = ADDRWIDTH + 1;
    localparam logic [CW-1:0]   LAST_WORD = CW'(MEMDEPTH - 1);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(MEMDEPTH);
    localparam bit              FULL      = (MEMDEPTH == (1 << ADDRWIDTH));
    localparam bit              DO_CLEAR  = (CLEAR_ON_RESET != 0);

    if ((DATAWIDTH % 8) != 0 || DATAWIDTH < 8
        || (READ_LATENCY != READ_LATENCY_MIN && READ_LATENCY != READ_LATENCY_MAX)
        || MEMDEPTH > (1 << ADDRWIDTH) || MEMDEPTH < 1) begin : g_bad_cfg
        $error("sram_bank: illegal parameter combination");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (!DO_CLEAR) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_WORD) begin
                    state_d = RUN;
                end
            end
        end
    end

    logic accept, in_range, sweep;
    logic [DATAWIDTH-1:0] arr_rdata;

    assign REQ_READY = (state_q == RUN);
    assign INIT_DONE = (state_q == RUN);
    assign accept    = REQ_VALID && REQ_READY;
    assign in_range  = FULL || ({1'b0, ADDRESS} < DEPTH_C);
    assign sweep     = (state_q == INIT) && DO_CLEAR;

    // The sweep owns the array port during INIT; out-of-range requests never reach it.
    sram_array #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .MEMDEPTH  (MEMDEPTH)
    ) u_array (
        .clk_i   (CLK),
        .en_i    (sweep || (accept && in_range)),
        .we_i    (sweep || REQ_WRITE),
        .addr_i  (sweep ? cnt_q[ADDRWIDTH-1:0] : ADDRESS),
        .be_i    (sweep ? {(DATAWIDTH/8){1'b1}} : WSTRB),
        .wdata_i (sweep ? {DATAWIDTH{1'b0}} : WDATA),
        .rdata_o (arr_rdata)
    );

    logic v1_q, e1_q, werr_q, rd_err;
    logic [DATAWIDTH-1:0] s1_data;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            v1_q   <= 1'b0;
            e1_q   <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            v1_q   <= accept && !REQ_WRITE;
            e1_q   <= accept && !REQ_WRITE && !in_range;
            werr_q <= accept && REQ_WRITE && !in_range;
        end
    end

    assign s1_data = e1_q ? '0 : arr_rdata;

    if (READ_LATENCY == READ_LATENCY_MAX) begin : g_lat2
        logic                 v2_q, e2_q;
        logic [DATAWIDTH-1:0] rdata_q;

        always_ff @(posedge CLK) begin
            if (!RSTn) begin
                v2_q    <= 1'b0;
                e2_q    <= 1'b0;
                rdata_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                if (v1_q) begin
                    rdata_q <= s1_data;
                end
            end
        end

        assign RVALID = v2_q;
        assign RDATA  = rdata_q;
        assign rd_err = e2_q;
    end else begin : g_lat1
        logic [DATAWIDTH-1:0] hold_q;

        always_ff @(posedge CLK) begin
            if (!RSTn) begin
                hold_q <= '0;
            end else if (v1_q) begin
                hold_q <= s1_data;
            end
        end

        assign RVALID = v1_q;
        assign RDATA  = v1_q ? s1_data : hold_q;
        assign rd_err = e1_q;
    end

    assign ERR_ADDR = rd_err || werr_q;

endmodule

// File: tb/tb_sram_bank.sv
// tb/tb_sram_bank.sv - scoreboard bench for sram_bank: 16-word/latency-1 and 12-word/latency-2 banks
module tb_sram_bank;

    localparam int NDUT = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_write;
    logic [3:0]  address, wstrb;
    logic [31:0] wdata;
    logic        req_ready [NDUT];
    logic        rvalid    [NDUT];
    logic        init_done [NDUT];
    logic        err_addr  [NDUT];
    logic [31:0] rdata     [NDUT];

    exp_t        exp_q   [NDUT][$];
    logic [31:0] mem_m   [NDUT][16];
    bit          err_exp [NDUT][4096];
    logic [31:0] last_rd [NDUT];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rst_seen;

    always #5 clk = ~clk;

    sram_bank #(
        .DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_a (
        .CLK(clk), .RSTn(rstn), .REQ_VALID(req_valid), .REQ_READY(req_ready[0]),
        .REQ_WRITE(req_write), .ADDRESS(address), .WSTRB(wstrb), .WDATA(wdata),
        .RVALID(rvalid[0]), .RDATA(rdata[0]), .INIT_DONE(init_done[0]), .ERR_ADDR(err_addr[0])
    );

    sram_bank #(
        .DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_b (
        .CLK(clk), .RSTn(rstn), .REQ_VALID(req_valid), .REQ_READY(req_ready[1]),
        .REQ_WRITE(req_write), .ADDRESS(address), .WSTRB(wstrb), .WDATA(wdata),
        .RVALID(rvalid[1]), .RDATA(rdata[1]), .INIT_DONE(init_done[1]), .ERR_ADDR(err_addr[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic void chk(input string name, input int d, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h, want %h", name, d, cyc, act, exp);
        end
    endfunction

    // Monitor: samples just after each rising edge and pops the scoreboard on RVALID.
    always begin
        @(posedge clk);
        rst_seen = !rstn;
        #1;
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (rst_seen) begin
                last_rd[d] = '0;
                chk("rst_rvalid", d, 32'(rvalid[d]), 0);
                chk("rst_rdata", d, rdata[d], 0);
                chk("rst_err_addr", d, 32'(err_addr[d]), 0);
                chk("rst_req_ready", d, 32'(req_ready[d]), 0);
                chk("rst_init_done", d, 32'(init_done[d]), 0);
            end else begin
                chk("err_addr", d, 32'(err_addr[d]), (cyc < 4096) ? 32'(err_exp[d][cyc]) : 0);
                if (rvalid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_rvalid dut%0d cycle %0d: got rvalid 1, want 0", d, cyc);
                    end else begin
                        exp_t e;
                        e = exp_q[d].pop_front();
                        chk("rvalid_cycle", d, cyc, e.due);
                        chk("rdata", d, rdata[d], e.data);
                        last_rd[d] = e.data;
                    end
                end else begin
                    chk("rdata_hold", d, rdata[d], last_rd[d]);
                    if (exp_q[d].size() > 0 && exp_q[d][0].due < cyc) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL missing_rvalid dut%0d cycle %0d: got none, want due %0d",
                                 d, cyc, exp_q[d][0].due);
                        void'(exp_q[d].pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [3:0] a, input logic [3:0] s,
                         input logic [31:0] w);
        req_valid = 1'b1;
        req_write = we;
        address   = a;
        wstrb     = s;
        wdata     = w;
        for (int d = 0; d < NDUT; d++) begin
            bit   inr;
            exp_t e;
            chk("req_ready", d, 32'(req_ready[d]), 1);
            inr = (int'(a) < depth_of(d));
            if (we) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) mem_m[d][a][8*b +: 8] = w[8*b +: 8];
                    end
                end else begin
                    err_exp[d][cyc + 1] = 1'b1;
                end
            end else begin
                e.due  = cyc + lat_of(d);
                e.data = inr ? mem_m[d][a] : 32'h0;
                exp_q[d].push_back(e);
                if (!inr) err_exp[d][e.due] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            req_valid = 1'b0;
            req_write = 1'($urandom_range(0, 1));
            address   = 4'($urandom_range(0, 15));
            wstrb     = 4'($urandom_range(0, 15));
            wdata     = $urandom;
            @(negedge clk);
        end
    endtask

    // Reset for ncyc edges, drop results that the reset kills, then time the clear sweep.
    task automatic do_reset(input int ncyc);
        int r;
        int rise [NDUT];
        rstn      = 1'b0;
        req_valid = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            while (exp_q[d].size() > 0 && exp_q[d][exp_q[d].size()-1].due > cyc) begin
                void'(exp_q[d].pop_back());
            end
            for (int c = cyc + 1; c < cyc + 4; c++) err_exp[d][c] = 1'b0;
            for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
            rise[d] = -1;
        end
        repeat (ncyc) @(negedge clk);
        rstn = 1'b1;
        r    = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (rise[d] < 0 && init_done[d]) rise[d] = cyc;
                if (rise[d] < 0) chk("ready_low_in_init", d, 32'(req_ready[d]), 0);
            end
            if (rise[0] >= 0 && rise[1] >= 0) break;
        end
        for (int d = 0; d < NDUT; d++) begin
            chk("init_done_rise", d, rise[d], r + depth_of(d));
            chk("ready_after_init", d, 32'(req_ready[d]), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        address   = '0;
        wstrb     = '0;
        wdata     = '0;
        for (int d = 0; d < NDUT; d++) last_rd[d] = '0;
        @(negedge clk);
        do_reset(3);

        issue(0, 4'd5, 4'h0, 32'h0);
        idle(2);
        issue(1, 4'd3, 4'hF, 32'hAABBCCDD);
        issue(1, 4'd3, 4'b0101, 32'h11223344);
        issue(0, 4'd3, 4'h0, 32'h0);
        idle(3);
        issue(0, 4'd0, 4'h0, 32'h0);
        issue(0, 4'd1, 4'h0, 32'h0);
        issue(0, 4'd2, 4'h0, 32'h0);
        idle(3);
        issue(1, 4'd7, 4'hF, 32'h12345678);
        issue(0, 4'd7, 4'h0, 32'h0);
        idle(3);
        issue(1, 4'd13, 4'hF, 32'hCAFEF00D);
        issue(0, 4'd13, 4'h0, 32'h0);
        issue(0, 4'd1, 4'h0, 32'h0);
        idle(3);
        issue(1, 4'd2, 4'h0, 32'hFFFFFFFF);
        issue(0, 4'd2, 4'h0, 32'h0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), $urandom);
            end
        end
        idle(4);

        issue(1, 4'd5, 4'hF, 32'hDEADBEEF);
        issue(0, 4'd5, 4'h0, 32'h0);
        do_reset(1);
        issue(0, 4'd5, 4'h0, 32'h0);
        issue(0, 4'd3, 4'h0, 32'h0);
        issue(0, 4'd13, 4'h0, 32'h0);
        idle(6);

        for (int d = 0; d < NDUT; d++) chk("scoreboard_drained", d, exp_q[d].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
